// File: rtl/mlp_stream_engine.sv
// mlp_stream_engine: streaming two-layer integer MLP (dense, ReLU requant, dense, argmax)
// fed one pixel per beat, with weights read from external 1-cycle synchronous ROMs.
module mlp_stream_engine #(
   parameter int IN_SIZE  = 784,
   parameter int HID_SIZE = 32,
   parameter int OUT_SIZE = 10,
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 20,
   parameter int SHIFT    = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_W-1:0]              s_data,
   input  logic                           s_last,
   output logic                           w1_rd_en,
   output logic [$clog2(IN_SIZE)-1:0]     w1_addr,
   input  logic [HID_SIZE*DATA_W-1:0]     w1_rdata,
   output logic                           w2_rd_en,
   output logic [$clog2(HID_SIZE)-1:0]    w2_addr,
   input  logic [OUT_SIZE*DATA_W-1:0]     w2_rdata,
   input  logic [HID_SIZE*DATA_W-1:0]     b1,
   input  logic [OUT_SIZE*DATA_W-1:0]     b2,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [$clog2(OUT_SIZE)-1:0]    m_digit,
   output logic [ACC_W-1:0]               m_score,
   output logic                           m_err_len,
   output logic                           busy
);
   localparam int IA = $clog2(IN_SIZE);
   localparam int HA = $clog2(HID_SIZE);
   localparam int OA = $clog2(OUT_SIZE);
   localparam int CW = $clog2(IN_SIZE + 1);
   localparam int LW = $clog2(HID_SIZE + 1);
   localparam int PW = 2 * DATA_W + 1;
   localparam int SW = (ACC_W > PW ? ACC_W : PW) + 1;

   typedef enum logic [2:0] {IDLE, L1, L1_DRAIN, DROP, ACT, L2, MAX, OUT} state_t;

   state_t                   state;
   logic signed [ACC_W-1:0]  acc1 [HID_SIZE];
   logic signed [ACC_W-1:0]  acc2 [OUT_SIZE];
   logic [DATA_W-1:0]        act  [HID_SIZE];
   logic [DATA_W-1:0]        pix;
   logic                     mac_v;
   logic                     err;
   logic [CW-1:0]            cnt;
   logic [CW-1:0]            nb;
   logic [LW-1:0]            l2c;
   logic [OA-1:0]            mc;
   logic [OA-1:0]            bi;
   logic [OA-1:0]            nd;
   logic signed [ACC_W-1:0]  best;
   logic signed [ACC_W-1:0]  ns;
   logic                     gt;

   // unsigned operand times signed weight, added with saturation instead of wrap
   function automatic logic signed [ACC_W-1:0] mac(input logic signed [ACC_W-1:0] a,
                                                   input logic [DATA_W-1:0] x,
                                                   input logic signed [DATA_W-1:0] w);
      logic signed [PW-1:0] p;
      logic signed [SW-1:0] s;
      p = PW'($signed({1'b0, x})) * PW'(w);
      s = SW'(a) + SW'(p);
      return (s[SW-1:ACC_W-1] == {(SW-ACC_W+1){s[SW-1]}}) ? s[ACC_W-1:0]
                                                           : {s[SW-1], {(ACC_W-1){~s[SW-1]}}};
   endfunction

   function automatic logic [DATA_W-1:0] relu(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] t;
      t = a >>> SHIFT;
      return t[ACC_W-1] ? '0 : |t[ACC_W-2:DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}} : t[DATA_W-1:0];
   endfunction

   assign nb       = (state == IDLE) ? CW'(1) : cnt + CW'(1);
   assign w1_rd_en = s_valid && s_ready && (state == IDLE || state == L1);
   assign w1_addr  = IA'(nb - CW'(1));
   assign w2_rd_en = (state == L2) && (l2c < LW'(HID_SIZE));
   assign w2_addr  = HA'(l2c);
   assign busy     = (state != IDLE);
   assign gt       = acc2[mc] > best;
   assign nd       = (mc == '0 || gt) ? mc : bi;
   assign ns       = (mc == '0 || gt) ? acc2[mc] : best;

   // layer 1: a beat's ROM row arrives the cycle after its strobe, so the pixel waits one cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mac_v <= 1'b0;
         pix   <= '0;
         for (int h = 0; h < HID_SIZE; h++) acc1[h] <= '0;
      end else begin
         mac_v <= w1_rd_en;
         if (w1_rd_en) pix <= s_data;
         for (int h = 0; h < HID_SIZE; h++)
            if (state == IDLE && w1_rd_en) acc1[h] <= ACC_W'($signed(b1[h*DATA_W +: DATA_W]));
            else if (mac_v) acc1[h] <= mac(acc1[h], pix, w1_rdata[h*DATA_W +: DATA_W]);
      end

   // layer 2: row k is read in L2 cycle k and accumulated in cycle k+1
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int h = 0; h < HID_SIZE; h++) act[h] <= '0;
         for (int o = 0; o < OUT_SIZE; o++) acc2[o] <= '0;
      end else if (state == ACT) begin
         for (int h = 0; h < HID_SIZE; h++) act[h] <= relu(acc1[h]);
         for (int o = 0; o < OUT_SIZE; o++) acc2[o] <= ACC_W'($signed(b2[o*DATA_W +: DATA_W]));
      end else if (state == L2 && l2c != '0) begin
         for (int o = 0; o < OUT_SIZE; o++)
            acc2[o] <= mac(acc2[o], act[HA'(l2c - LW'(1))], w2_rdata[o*DATA_W +: DATA_W]);
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         s_ready   <= 1'b0;
         cnt       <= '0;
         err       <= 1'b0;
         l2c       <= '0;
         mc        <= '0;
         bi        <= '0;
         best      <= '0;
         m_valid   <= 1'b0;
         m_digit   <= '0;
         m_score   <= '0;
         m_err_len <= 1'b0;
      end else begin
         case (state)
            IDLE, L1: begin
               s_ready <= 1'b1;
               if (s_valid && s_ready) begin
                  cnt <= nb;
                  if (s_last) begin
                     err     <= (nb != CW'(IN_SIZE));
                     s_ready <= 1'b0;
                     state   <= L1_DRAIN;
                  end else if (nb == CW'(IN_SIZE)) begin
                     err   <= 1'b1;
                     state <= DROP;
                  end else state <= L1;
               end
            end
            DROP: if (s_valid && s_ready && s_last) begin
               s_ready <= 1'b0;
               state   <= L1_DRAIN;
            end
            L1_DRAIN: state <= ACT;
            ACT: begin
               l2c   <= '0;
               mc    <= '0;
               state <= L2;
            end
            L2: begin
               l2c <= l2c + LW'(1);
               if (l2c == LW'(HID_SIZE)) state <= MAX;
            end
            MAX: begin
               mc   <= mc + OA'(1);
               bi   <= nd;
               best <= ns;
               if (mc == OA'(OUT_SIZE - 1)) begin
                  m_digit   <= nd;
                  m_score   <= ns;
                  m_err_len <= err;
                  m_valid   <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: if (m_ready) begin
               m_valid <= 1'b0;
               s_ready <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mlp_stream_engine.sv
// tb_mlp_stream_engine: directed frames with hand-computed results; a scoreboard queue
// holds the expected result of each frame and a monitor checks every presented output.
module tb_mlp_stream_engine;
   localparam int IN  = 784;
   localparam int HID = 32;
   localparam int OUT = 10;
   localparam int DW  = 8;
   localparam int AW  = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic s_valid = 1'b0;
   logic s_last = 1'b0;
   logic m_ready = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic s_ready, w1_rd_en, w2_rd_en, m_valid, m_err_len, busy;
   logic [9:0] w1_addr;
   logic [4:0] w2_addr;
   logic [HID*DW-1:0] w1_rdata, b1;
   logic [OUT*DW-1:0] w2_rdata, b2;
   logic [3:0] m_digit;
   logic [AW-1:0] m_score;

   typedef struct {int digit; int score; int err; int lat;} exp_t;
   exp_t sb[$];
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic signed [DW-1:0] w1v = '0;
   logic signed [DW-1:0] w2l [OUT];
   int w1_lo = 1024;

   mlp_stream_engine #(.IN_SIZE(IN), .HID_SIZE(HID), .OUT_SIZE(OUT), .DATA_W(DW), .ACC_W(AW), .SHIFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .w1_rd_en(w1_rd_en), .w1_addr(w1_addr), .w1_rdata(w1_rdata),
      .w2_rd_en(w2_rd_en), .w2_addr(w2_addr), .w2_rdata(w2_rdata),
      .b1(b1), .b2(b2), .m_valid(m_valid), .m_ready(m_ready), .m_digit(m_digit),
      .m_score(m_score), .m_err_len(m_err_len), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // layer-1 ROM: rows below w1_lo (and any out-of-range row) hold w1v in every lane
   always @(posedge clk) begin
      logic signed [DW-1:0] rv;
      rv = (int'(w1_addr) < w1_lo || int'(w1_addr) >= IN) ? w1v : 8'sd0;
      if (w1_rd_en) w1_rdata <= {HID{rv}};
   end

   always @(posedge clk)
      if (w2_rd_en) for (int o = 0; o < OUT; o++) w2_rdata[o*DW +: DW] <= w2l[o];

   task automatic chk(input string nm, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", nm, a, e);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int pm, input int i);
      return pm == 0 ? 8'(i) : pm == 1 ? 8'd1 : pm == 2 ? 8'd255 : (i < IN ? 8'd1 : 8'd255);
   endfunction

   task automatic set_cfg(input int wv, input int lo, input int b1v, input int b2v, input int b2h,
                          input int b2hv, input int w2v, input int w2h, input int w2hv);
      w1v   = 8'(wv);
      w1_lo = lo;
      for (int h = 0; h < HID; h++) b1[h*DW +: DW] = 8'(b1v);
      for (int o = 0; o < OUT; o++) begin
         b2[o*DW +: DW] = 8'(o == b2h ? b2hv : b2v);
         w2l[o] = 8'(o == w2h ? w2hv : w2v);
      end
   endtask

   task automatic send_frame(input int n, input int pm, input int gaps, input int abort_at,
                             input int ed, input int es, input int ee);
      for (int i = 0; i < n; i++) begin
         int t;
         logic ok;
         if (gaps != 0 && $urandom_range(3) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(4, 1)) @(posedge clk);
            #1;
         end
         s_valid = 1'b1;
         s_data  = pix(pm, i);
         s_last  = (i == n - 1);
         t = 0;
         do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            t++;
         end while (!ok && t < 1000);
         if (!ok) begin
            chk("s_ready_wait", int'(ok), 1);
            s_valid = 1'b0;
            return;
         end
         if (i + 1 == abort_at) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      sb.push_back('{ed, es, ee, cyc + 45});
   endtask

   task automatic wait_done();
      int t = 0;
      while (sb.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      chk("result_drain", sb.size(), 0);
      #1;
   endtask

   task automatic monitor();
      logic pv = 1'b0;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("result_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               if (!pv) chk("latency", cyc, sb[0].lat);
               chk("m_digit", int'(m_digit), sb[0].digit);
               chk("m_score", int'($signed(m_score)), sb[0].score);
               chk("m_err_len", int'(m_err_len), sb[0].err);
               if (m_ready) void'(sb.pop_front());
            end
         end
         pv = m_valid && !m_ready;
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      set_cfg(0, 1024, 0, 0, -1, 0, 0, -1, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_w1_rd_en", int'(w1_rd_en), 0);
      chk("rst_w2_rd_en", int'(w2_rd_en), 0);
      chk("rst_m_digit", int'(m_digit), 0);
      chk("rst_m_score", int'(m_score), 0);
      chk("rst_m_err_len", int'(m_err_len), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // zero weights, only bias lane 3 set
      set_cfg(0, 1024, 0, 0, 3, 5, 0, -1, 0);
      send_frame(IN, 0, 0, 0, 3, 5, 0);
      wait_done();
      // act saturates at 127, lane 7 doubled: 32*127*2
      set_cfg(1, 1024, 0, 0, -1, 0, 1, 7, 2);
      send_frame(IN, 1, 0, 0, 7, 8128, 0);
      wait_done();
      // short frame, b1=-50: act=50, lane 7 = 32*50*2
      set_cfg(1, 1024, -50, 0, -1, 0, 1, 7, 2);
      send_frame(100, 1, 0, 0, 7, 3200, 1);
      wait_done();
      // accumulator saturation; 17 beats already exceed 2^19-1 and would wrap negative
      set_cfg(127, 1024, 0, 0, -1, 0, 0, 4, 1);
      send_frame(IN, 2, 0, 0, 4, 4064, 0);
      wait_done();
      send_frame(17, 2, 0, 0, 4, 4064, 1);
      wait_done();
      // ties resolve to the lowest index
      set_cfg(0, 1024, 0, 9, -1, 0, 0, -1, 0);
      send_frame(IN, 1, 0, 0, 0, 9, 0);
      wait_done();
      set_cfg(0, 1024, 0, -3, 5, 7, 0, -1, 0);
      send_frame(IN, 1, 0, 0, 5, 7, 0);
      wait_done();
      set_cfg(0, 1024, 0, -3, -1, 0, 0, -1, 0);
      send_frame(IN, 1, 0, 0, 0, -3, 0);
      wait_done();
      // overlong frame: only rows 0..2 weigh in, so act=3; extra beats of 255 must be dropped
      set_cfg(1, 3, 0, 0, -1, 0, 1, 7, 2);
      send_frame(790, 3, 0, 0, 7, 192, 1);
      wait_done();
      send_frame(IN, 3, 0, 0, 7, 192, 0);
      wait_done();
      // random input gaps and a result held 20 cycles by m_ready low
      set_cfg(1, 1024, 0, 0, -1, 0, 1, 7, 2);
      m_ready = 1'b0;
      send_frame(IN, 1, 1, 0, 7, 8128, 0);
      repeat (65) @(posedge clk);
      #1;
      m_ready = 1'b1;
      wait_done();
      // reset mid-L1 abandons the frame
      send_frame(IN, 1, 0, 50, 0, 0, 0);
      chk("busy_mid_frame", int'(busy), 1);
      rst_n = 1'b0;
      #2;
      chk("abort_busy", int'(busy), 0);
      chk("abort_s_ready", int'(s_ready), 0);
      chk("abort_m_valid", int'(m_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("abort_no_result", int'(m_valid), 0);
      send_frame(IN, 1, 0, 0, 7, 8128, 0);
      wait_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mlp_stream_engine.md
Name: mlp_stream_engine

Overview:
- Parametrised successor to the fixed 784-32-10 MNIST accelerator core. It runs a two-layer integer MLP (dense, ReLU with requantisation, dense, argmax) on a pixel stream.
- Pixels arrive one per beat over a valid/ready handshake instead of a 6272-bit parallel bus. Weights are read from external synchronous ROMs. The result leaves on a valid/ready handshake carrying the winning index, its score and a frame-length error flag.
- Sits between the image source (UART/BRAM loader) and the digit display/host logic.

Parameters:
- IN_SIZE, 784, input features per frame.
- HID_SIZE, 32, hidden neurons.
- OUT_SIZE, 10, output classes (>=2).
- DATA_W, 8, pixel/weight/bias/activation width.
- ACC_W, 20, accumulator width.
- SHIFT, 0, arithmetic right shift applied to layer-1 sums before ReLU.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  pixel beat valid.
- s_ready  out  1  engine accepts pixel.
- s_data  in  DATA_W  pixel, unsigned.
- s_last  in  1  last beat of frame.
- w1_rd_en  out  1  layer-1 ROM read strobe.
- w1_addr  out  clog2(IN_SIZE)  row = pixel index.
- w1_rdata  in  HID_SIZE*DATA_W  signed weights for that pixel, lane h at [h*DATA_W +: DATA_W]; valid 1 cycle after strobe.
- w2_rd_en  out  1  layer-2 ROM read strobe.
- w2_addr  out  clog2(HID_SIZE)  row = hidden index.
- w2_rdata  in  OUT_SIZE*DATA_W  signed weights, 1-cycle latency.
- b1  in  HID_SIZE*DATA_W  signed layer-1 biases, static during a frame.
- b2  in  OUT_SIZE*DATA_W  signed layer-2 biases, static during a frame.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed.
- m_digit  out  clog2(OUT_SIZE)  argmax index.
- m_score  out  ACC_W  signed winning score.
- m_err_len  out  1  frame length differed from IN_SIZE.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async, rst_n low): state IDLE, all accumulators and activation registers 0, s_ready 0, w1_rd_en 0, w2_rd_en 0, m_valid 0, m_digit 0, m_score 0, m_err_len 0, busy 0. Reset asserted mid-frame abandons the frame; no partial result is ever emitted.
- States: IDLE, L1, L1_DRAIN, DROP, ACT, L2, MAX, OUT.
- IDLE: s_ready=1. The first accepted beat (s_valid&&s_ready) loads each layer-1 accumulator with sign-extended b1[h], sets pixel count to 1, and enters L1.
- L1: s_ready=1.
  - Each accepted beat issues w1_rd_en=1 with w1_addr = beat index, and registers the pixel.
  - On the next cycle, acc1[h] += {0,pixel} * w1_rdata[h] for all h in parallel.
  - Stalls (s_valid=0) insert bubbles; no MAC occurs on bubble cycles.
- Frame end:
  - s_last on beat n<IN_SIZE: remaining pixels are treated as 0 (no further MACs), m_err_len=1, go to L1_DRAIN.
  - s_last on beat IN_SIZE: m_err_len=0, go to L1_DRAIN.
  - Beat IN_SIZE without s_last: m_err_len=1, go to DROP.
- DROP: s_ready=1; beats are discarded until a beat with s_last, then go to L1_DRAIN. Pixels are never carried into the next frame.
- L1_DRAIN: 1 cycle, s_ready=0; completes the final MAC.
- ACT: 1 cycle. act[h] = clamp(acc1[h] >>> SHIFT, 0, 2^(DATA_W-1)-1).
- L2:
  - Layer-2 accumulators are preloaded with sign-extended b2.
  - Reads rows 0..HID_SIZE-1 on consecutive cycles; each row's MAC uses act[k] one cycle after its read.
  - L2 lasts HID_SIZE+1 cycles.
- MAX:
  - Sequential scan, one class per cycle, OUT_SIZE cycles.
  - Strict greater-than comparison, so ties resolve to the lowest index.
  - At the end, latches m_digit, m_score and m_err_len.
- OUT: m_valid=1. Outputs are held stable while m_valid&&!m_ready. The handshake completes on m_valid&&m_ready, after which m_valid drops and the state returns to IDLE. s_ready=0 in OUT, so there is no overlap with the next frame.
- Latency: with no stalls, m_valid rises exactly 3+HID_SIZE+OUT_SIZE cycles after the edge accepting the frame's final beat (45 at defaults).
- Arithmetic:
  - Every MAC saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; it never wraps.
  - Products are formed at DATA_W*2+1 bits before the add.
- w1_rd_en and w2_rd_en are never high outside L1 and L2 respectively.

Test Plan:
- All weights 0, b1=0, b2 lane 3 = 5, others 0; 784 beats with s_last on beat 784 -> m_digit=3, m_score=5, m_err_len=0, m_valid 45 cycles after last beat.
- Every pixel=1, w1 all +1, SHIFT=0, b1=0 -> act saturates at 127; w2 row all +1 except lane 7 = +2, b2=0 -> m_digit=7, m_score=32*127*2=8128.
- Saturation: w1 all +127, pixels 255, SHIFT=0 -> acc1 clamps at 524287, no wrap to negative.
- b2 all equal (say 9), weights 0 -> m_digit=0 (lowest-index tie), m_score=9.
- s_last on beat 100 -> m_err_len=1, result produced. Separately, 790 beats with s_last on 790 -> beats 785-790 dropped, m_err_len=1, next frame is correct.
- Random s_valid gaps plus m_ready held low 20 cycles -> outputs stable, single handshake. rst_n pulsed low mid-L1 -> m_valid never asserts for that frame, next frame is correct.
